// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bus: decoder/register-file inputs, stall enables and EX-side register outputs.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [7:0]        ConMux_i;
  logic              Flush_i;
  logic              Hold_i;
  logic [4:0]        IFID_Rs_i;
  logic [4:0]        IFID_Rt_i;
  logic [4:0]        IFID_Rd_i;
  logic [DATA_W-1:0] RSdata_i;
  logic [DATA_W-1:0] RTdata_i;
  logic [DATA_W-1:0] Imm_i;

  logic              PCWrite_o;
  logic              IFIDWrite_o;
  logic              RegWrite_o;
  logic              MemtoReg_o;
  logic              MemRead_o;
  logic              MemWrite_o;
  logic              ALUSrc_o;
  logic              RegDst_o;
  logic [1:0]        ALUOp_o;
  logic [DATA_W-1:0] RSdata_o;
  logic [DATA_W-1:0] RTdata_o;
  logic [DATA_W-1:0] Imm_o;
  logic [4:0]        Rs_o;
  logic [4:0]        Rt_o;
  logic [4:0]        Rd_o;
  logic              Valid_o;
  logic [CNT_W-1:0]  BubbleCnt_o;

  modport master (
    output ConMux_i, Flush_i, Hold_i, IFID_Rs_i, IFID_Rt_i, IFID_Rd_i,
           RSdata_i, RTdata_i, Imm_i,
    input  PCWrite_o, IFIDWrite_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
           ALUSrc_o, RegDst_o, ALUOp_o, RSdata_o, RTdata_o, Imm_o, Rs_o, Rt_o, Rd_o,
           Valid_o, BubbleCnt_o
  );

  modport slave (
    input  ConMux_i, Flush_i, Hold_i, IFID_Rs_i, IFID_Rt_i, IFID_Rd_i,
           RSdata_i, RTdata_i, Imm_i,
    output PCWrite_o, IFIDWrite_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
           ALUSrc_o, RegDst_o, ALUOp_o, RSdata_o, RTdata_o, Imm_o, Rs_o, Rt_o, Rd_o,
           Valid_o, BubbleCnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic         clk_i,
  input logic         rst_n_i,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic              reg_dst;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              valid;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard_c;
  logic             advance_c;

  // Load in EX whose destination is read by the instruction in ID.
  assign hazard_c = ex_q.mem_read & ex_q.valid & (ex_q.rt != 5'd0) &
                    ((ex_q.rt == bus.IFID_Rs_i) | (ex_q.rt == bus.IFID_Rt_i));

  // A flush discards the ID instruction, so a hazard against it must not stall the front end.
  assign advance_c       = ~bus.Hold_i & ~(hazard_c & ~bus.Flush_i);
  assign bus.PCWrite_o   = advance_c;
  assign bus.IFIDWrite_o = advance_c;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.Hold_i) begin
      ex_d  = ex_q;
    end else if (bus.Flush_i) begin
      ex_d  = '0;
    end else if (hazard_c) begin
      ex_d  = '0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      {ex_d.reg_write, ex_d.mem_to_reg, ex_d.mem_read, ex_d.mem_write,
       ex_d.alu_src, ex_d.alu_op, ex_d.reg_dst} = bus.ConMux_i;
      ex_d.rs      = bus.IFID_Rs_i;
      ex_d.rt      = bus.IFID_Rt_i;
      ex_d.rd      = bus.IFID_Rd_i;
      ex_d.rs_data = bus.RSdata_i;
      ex_d.rt_data = bus.RTdata_i;
      ex_d.imm     = bus.Imm_i;
      ex_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.RegWrite_o  = ex_q.reg_write;
  assign bus.MemtoReg_o  = ex_q.mem_to_reg;
  assign bus.MemRead_o   = ex_q.mem_read;
  assign bus.MemWrite_o  = ex_q.mem_write;
  assign bus.ALUSrc_o    = ex_q.alu_src;
  assign bus.ALUOp_o     = ex_q.alu_op;
  assign bus.RegDst_o    = ex_q.reg_dst;
  assign bus.Rs_o        = ex_q.rs;
  assign bus.Rt_o        = ex_q.rt;
  assign bus.Rd_o        = ex_q.rd;
  assign bus.RSdata_o    = ex_q.rs_data;
  assign bus.RTdata_o    = ex_q.rt_data;
  assign bus.Imm_o       = ex_q.imm;
  assign bus.Valid_o     = ex_q.valid;
  assign bus.BubbleCnt_o = cnt_q;

endmodule
